// File: rtl/md_issue_ctrl.sv
// -----------------------------------------------------------------------------
// md_issue_ctrl
//
// E-stage initiator for the multiply/divide unit. Classifies the md-class
// request in E, launches long ops (MULT/MULTU/DIV/DIVU) and moves (MTHI/MTLO)
// into the unit with a registered one-cycle Start pulse, and stalls the front
// of the pipeline while the unit is occupied. MFHI/MFLO reads are served
// combinationally from the unit's HI/LO once no result is outstanding.
//
// The controller remembers an issued long op from the Start cycle until it
// has seen Busy low again. This covers the one-cycle gap between Start and
// Busy rising, so the pipeline never sees a false "idle".
//
// Parameters
//   MAX_WAIT  busy cycles tolerated in one busy period before timeout_err sets
//   CNT_W     wait counter width, 2**CNT_W must exceed MAX_WAIT
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req_valid/op/a/b      md-class request presented in E this cycle
//   req_flush             exception/eret in E or later, kills this request
//   md_busy, md_hi, md_lo status and results from the mul/div unit
//   md_start/op/d1/d2     registered launch interface to the unit
//   stall                 freeze F/D/E this cycle (combinational)
//   rd_data, rd_valid     MFHI/MFLO result and its qualifier (combinational)
//   timeout_err           sticky: a busy period reached MAX_WAIT cycles
//
// Build option
//   MD_PERF_CNT_EN  when defined, adds stall_cycles (cycles with stall high)
//                   and issue_count (md_start pulses), both 32-bit, wrapping.
// -----------------------------------------------------------------------------
module md_issue_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_flush,
    input  logic        md_busy,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic        md_start,
    output logic [3:0]  md_op,
    output logic [31:0] md_d1,
    output logic [31:0] md_d2,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        timeout_err
`ifdef MD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] issue_count
`endif
);

    localparam logic [3:0] OP_MULT  = 4'b0000;
    localparam logic [3:0] OP_MULTU = 4'b0001;
    localparam logic [3:0] OP_DIV   = 4'b0010;
    localparam logic [3:0] OP_DIVU  = 4'b0011;
    localparam logic [3:0] OP_MFHI  = 4'b0100;
    localparam logic [3:0] OP_MFLO  = 4'b0101;
    localparam logic [3:0] OP_MTHI  = 4'b0110;
    localparam logic [3:0] OP_MTLO  = 4'b0111;

    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] wait_cnt_s;
    logic             move_pending_r;

    logic             is_long_s;
    logic             is_move_s;
    logic             is_read_s;
    logic             is_legal_s;
    logic             req_live_s;
    logic             unit_active_s;
    logic             issue_s;
    logic             timeout_hit_s;

    // Request classification from the op code; illegal codes fall to default.
    always_comb begin
        is_long_s  = 1'b0;
        is_move_s  = 1'b0;
        is_read_s  = 1'b0;
        is_legal_s = 1'b0;
        case (req_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                is_long_s  = 1'b1;
                is_legal_s = 1'b1;
            end
            OP_MFHI, OP_MFLO: begin
                is_read_s  = 1'b1;
                is_legal_s = 1'b1;
            end
            OP_MTHI, OP_MTLO: begin
                is_move_s  = 1'b1;
                is_legal_s = 1'b1;
            end
            default: begin
                is_legal_s = 1'b0;
            end
        endcase
    end

    // Stall, issue and read-path decisions for the request in E.
    always_comb begin
        // The ISSUE state covers the cycle before Busy rises; WAIT holds
        // until Busy is seen low, so the unit is never reported idle early.
        unit_active_s = (state_r != ST_IDLE) || md_busy;
        req_live_s    = req_valid && !req_flush && is_legal_s;
        // A move launched last cycle has not written HI/LO yet, so a read
        // right behind it waits one more cycle.
        stall         = req_live_s && (unit_active_s || (is_read_s && move_pending_r));
        issue_s       = req_live_s && (is_long_s || is_move_s) && !unit_active_s;
        rd_valid      = req_valid && is_read_s && !stall && !req_flush;
        case (req_op)
            OP_MFHI: rd_data = md_hi;
            OP_MFLO: rd_data = md_lo;
            default: rd_data = 32'd0;
        endcase
    end

    // Next-state and wait-counter logic for one long-op busy period.
    always_comb begin
        state_s       = state_r;
        wait_cnt_s    = wait_cnt_r;
        timeout_hit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (issue_s && is_long_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s    = ST_WAIT;
                wait_cnt_s = CNT_ZERO;
            end
            ST_WAIT: begin
                if (md_busy) begin
                    state_s = ST_WAIT;
                    if (wait_cnt_r < MAX_WAIT_C) begin
                        wait_cnt_s = wait_cnt_r + CNT_ONE;
                    end else begin
                        wait_cnt_s = wait_cnt_r;
                    end
                    timeout_hit_s = (wait_cnt_s == MAX_WAIT_C);
                end else begin
                    // Flush never aborts an in-flight op; only Busy falling
                    // ends the period.
                    state_s    = ST_IDLE;
                    wait_cnt_s = CNT_ZERO;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                wait_cnt_s = CNT_ZERO;
            end
        endcase
    end

    // State, counter, hazard flag and sticky timeout registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            wait_cnt_r     <= CNT_ZERO;
            move_pending_r <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            state_r        <= state_s;
            wait_cnt_r     <= wait_cnt_s;
            move_pending_r <= issue_s && is_move_s;
            timeout_err    <= timeout_err || timeout_hit_s;
        end
    end

    // Registered launch interface; op and operands hold until the next issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_start <= 1'b0;
            md_op    <= 4'd0;
            md_d1    <= 32'd0;
            md_d2    <= 32'd0;
        end else begin
            md_start <= issue_s;
            if (issue_s) begin
                md_op <= req_op;
                md_d1 <= req_a;
                md_d2 <= req_b;
            end else begin
                md_op <= md_op;
                md_d1 <= md_d1;
                md_d2 <= md_d2;
            end
        end
    end

`ifdef MD_PERF_CNT_EN
    // Performance counters: stall cycles and Start pulses, both wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= 32'd0;
            issue_count  <= 32'd0;
        end else begin
            if (stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end else begin
                stall_cycles <= stall_cycles;
            end
            if (md_start) begin
                issue_count <= issue_count + 32'd1;
            end else begin
                issue_count <= issue_count;
            end
        end
    end
`else
    // Without the performance option there are no counters to maintain.
`endif

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- E-stage initiator for the multiply/divide unit. Accepts mult/div/mfhi/mflo/mthi/mtlo requests from the pipeline and drives the unit's Start/ALUOp/D1/D2 inputs.
- Consumes the unit's Busy/HI/LO outputs. Generates the pipeline stall, returns mfhi/mflo read data, and suppresses issue on exception flush.
- Covers the one-cycle gap between a Start pulse and Busy rising, so the pipeline never sees a false "idle".

Parameters:
- MAX_WAIT, 16: cycle limit for one busy period before the sticky timeout error sets.
- CNT_W, 5: width of the internal wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  md-class instruction present in E this cycle
- req_op  in  4  0000 MULT, 0001 MULTU, 0010 DIV, 0011 DIVU, 0100 MFHI, 0101 MFLO, 0110 MTHI, 0111 MTLO; other codes are illegal
- req_a  in  32  rs operand
- req_b  in  32  rt operand
- req_flush  in  1  exception/eret in E or later; kills this cycle's request
- md_busy  in  1  Busy from the mul/div unit
- md_hi  in  32  HI from the unit
- md_lo  in  32  LO from the unit
- md_start  out  1  one-cycle Start pulse to the unit
- md_op  out  4  op code to the unit, valid with md_start
- md_d1  out  32  operand 1 to the unit
- md_d2  out  32  operand 2 to the unit
- stall  out  1  freeze F/D/E this cycle (combinational)
- rd_data  out  32  MFHI/MFLO result (combinational)
- rd_valid  out  1  rd_data is usable this cycle
- timeout_err  out  1  sticky: a busy period exceeded MAX_WAIT

Behaviour:
- Reset values: md_start=0, md_op=0, md_d1=0, md_d2=0, timeout_err=0, state=IDLE, wait_cnt=0.
- Request classes:
  - long = MULT/MULTU/DIV/DIVU
  - move = MTHI/MTLO
  - read = MFHI/MFLO
  - Illegal codes are ignored: no stall, no start, rd_valid=0.
- unit_active = (state != IDLE) || md_busy.
- stall = req_valid && !req_flush && legal op && unit_active. This applies to all three classes, because MF* must wait for a final result.
- Issue condition: issue = req_valid && !req_flush && legal && !long-or-move-blocked, where blocked = unit_active.
- On issue, md_start, md_op, md_d1 and md_d2 are registered:
  - md_op = req_op, md_d1 = req_a, md_d2 = req_b.
  - md_start=1 for exactly one cycle, then md_start=0.
  - md_op, md_d1 and md_d2 hold their values until the next issue.
- Latency: from the request cycle to the md_start high cycle is 1 cycle.
- State machine:
  - IDLE: on issue of a long op -> ISSUE. Move ops pulse md_start and stay IDLE; the unit writes HI/LO in one cycle.
  - ISSUE: md_start=1. Always -> WAIT next cycle, wait_cnt=0.
  - WAIT: while md_busy=1, wait_cnt increments and saturates at MAX_WAIT. When md_busy=0 -> IDLE.
- Timeout: on reaching wait_cnt==MAX_WAIT, timeout_err sets. It clears only on reset.
- Move-to-read hazard: a move issued in cycle N keeps stall high for a read presented in cycle N+1. This is tracked by a 1-cycle move_pending flag.
- Read path:
  - rd_data = md_hi for MFHI, md_lo for MFLO, else 0.
  - rd_valid = req_valid && read && !stall && !req_flush.
- Flush rules:
  - req_flush in the request cycle: no issue, no stall.
  - req_flush during ISSUE/WAIT does not abort. The in-flight op completes and the state still returns to IDLE on busy fall.
- Simultaneous events:
  - A new long request in the cycle md_busy falls (WAIT) still stalls. state is still WAIT, so the request issues in the next cycle.
  - reset has priority over everything; any in-flight state is dropped to IDLE.
  - The unit is reset by the same signal.

Optional Feature:
- Macro: MD_PERF_CNT_EN.
- Defined: adds a 32-bit output stall_cycles, reset to 0.
  - Increments every cycle stall=1 and wraps at 2^32.
  - Adds a 32-bit output issue_count, incremented on every md_start pulse.
- Undefined: both ports and both counters are absent. Core behaviour is identical.

Test Plan:
- Reset held 2 cycles -> all outputs 0, state IDLE, stall=0 with req_valid=0.
- MULT with req_a=32'hffff_ffff, req_b=32'h2, unit Busy for 5 cycles -> md_start high exactly 1 cycle with md_op=0000, md_d1=ffff_ffff, md_d2=2. A following MFLO stalls until Busy falls, then rd_data=32'hffff_fffe, rd_valid=1.
- DIV issued, then a second DIVU presented during Busy -> stall=1 every cycle until Busy=0 plus the WAIT exit cycle. The second md_start fires 1 cycle after release.
- MTHI req_a=32'h1234 followed immediately by MFHI -> MFHI stalls 1 cycle (move_pending), then rd_data=32'h1234.
- MULT with req_flush=1 -> md_start stays 0, stall=0. Flush asserted during WAIT -> Busy still completes and state returns to IDLE.
- Unit model holds Busy for 20 cycles, MAX_WAIT=16 -> timeout_err=1 on wait_cnt==16 and stays 1 after Busy falls. With MD_PERF_CNT_EN, stall_cycles matches the bench count and issue_count=1.
